// File: rtl/alu_pkg.sv
// Shared definitions for the iterative execute-stage ALU.
// Holds the 6-bit Funct opcodes emitted by the ALU control decoder (which
// imports the same constants) and the execute FSM state type.
package alu_pkg;

  localparam int unsigned FUNCT_W = 6;

  localparam logic [FUNCT_W-1:0] FUNCT_ADDU = 6'b001011;
  localparam logic [FUNCT_W-1:0] FUNCT_SUBU = 6'b001101;
  localparam logic [FUNCT_W-1:0] FUNCT_AND  = 6'b010010;
  localparam logic [FUNCT_W-1:0] FUNCT_SLL  = 6'b100110;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } alu_state_t;

endpackage : alu_pkg

// File: rtl/alu_shifter.sv
// Iterative left shifter: one bit per step, zero fill.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   load       : capture load_val into the shift register and load_cnt into the counter
//   step       : shift left by one and decrement the counter
//   load_val   : value to be shifted
//   load_cnt   : number of remaining steps
//   shifted    : register contents shifted left by one (the value after this step)
//   last       : this step is the final one (counter is 1)
module alu_shifter #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned SHW   = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             step,
  input  logic [WIDTH-1:0] load_val,
  input  logic [SHW-1:0]   load_cnt,
  output logic [WIDTH-1:0] shifted,
  output logic             last
);

  logic [WIDTH-1:0] sreg_q;
  logic [SHW-1:0]   cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sreg_q <= '0;
      cnt_q  <= '0;
    end else if (load) begin
      sreg_q <= load_val;
      cnt_q  <= load_cnt;
    end else if (step) begin
      sreg_q <= shifted;
      cnt_q  <= cnt_q - SHW'(1);
    end
  end

  assign shifted = {sreg_q[WIDTH-2:0], 1'b0};
  assign last    = (cnt_q == SHW'(1));

endmodule : alu_shifter

// File: rtl/alu_iterative_exec.sv
// Execute-stage ALU: addu/subu/and complete in one cycle, sll shifts one bit
// per cycle. Result and flags are registered and held until the next completion.
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   start               : operation request, sampled only while busy is low
//   Funct               : opcode from the ALU control decoder
//   Src1, Src2          : operands (Src1 is the shifted value for sll, Src2 unused there)
//   Shamt               : shift amount for sll
//   Result              : registered result
//   Zero, Carry, Illegal: registered flags of the last completed operation
//   busy                : shift in progress, start is dropped
//   done                : one-cycle pulse when Result/flags first show a new value
module alu_iterative_exec
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned SHW   = 5
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [FUNCT_W-1:0] Funct,
  input  logic [WIDTH-1:0]   Src1,
  input  logic [WIDTH-1:0]   Src2,
  input  logic [SHW-1:0]     Shamt,
  output logic [WIDTH-1:0]   Result,
  output logic               Zero,
  output logic               Carry,
  output logic               Illegal,
  output logic               busy,
  output logic               done
);

  alu_state_t state_q, state_d;

  logic [WIDTH-1:0] result_q, result_d;
  logic             zero_q, zero_d;
  logic             carry_q, carry_d;
  logic             illegal_q, illegal_d;
  logic             done_q, done_d;

  logic             sh_load, sh_step, sh_last;
  logic [WIDTH-1:0] sh_shifted;

  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] diff;
  logic             borrow;

  // Single-cycle datapath; the extra sum bit is the carry-out.
  always_comb begin
    sum    = {1'b0, Src1} + {1'b0, Src2};
    diff   = Src1 - Src2;
    borrow = (Src1 < Src2);
  end

  alu_shifter #(
    .WIDTH (WIDTH),
    .SHW   (SHW)
  ) u_shifter (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (sh_load),
    .step     (sh_step),
    .load_val (Src1),
    .load_cnt (Shamt),
    .shifted  (sh_shifted),
    .last     (sh_last)
  );

  always_comb begin
    state_d   = state_q;
    result_d  = result_q;
    zero_d    = zero_q;
    carry_d   = carry_q;
    illegal_d = illegal_q;
    done_d    = 1'b0;
    sh_load   = 1'b0;
    sh_step   = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          case (Funct)
            FUNCT_ADDU: begin
              result_d  = sum[WIDTH-1:0];
              carry_d   = sum[WIDTH];
              illegal_d = 1'b0;
              done_d    = 1'b1;
            end
            FUNCT_SUBU: begin
              result_d  = diff;
              carry_d   = borrow;
              illegal_d = 1'b0;
              done_d    = 1'b1;
            end
            FUNCT_AND: begin
              result_d  = Src1 & Src2;
              carry_d   = 1'b0;
              illegal_d = 1'b0;
              done_d    = 1'b1;
            end
            FUNCT_SLL: begin
              if (Shamt == '0) begin
                result_d  = Src1;
                carry_d   = 1'b0;
                illegal_d = 1'b0;
                done_d    = 1'b1;
              end else begin
                sh_load = 1'b1;
                state_d = SHIFT;
              end
            end
            default: begin
              result_d  = '0;
              carry_d   = 1'b0;
              illegal_d = 1'b1;
              done_d    = 1'b1;
            end
          endcase
        end
      end
      SHIFT: begin
        sh_step = 1'b1;
        if (sh_last) begin
          result_d  = sh_shifted;
          carry_d   = 1'b0;
          illegal_d = 1'b0;
          done_d    = 1'b1;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Zero only changes together with Result.
    if (done_d) begin
      zero_d = (result_d == '0);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      result_q  <= '0;
      zero_q    <= 1'b0;
      carry_q   <= 1'b0;
      illegal_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      result_q  <= result_d;
      zero_q    <= zero_d;
      carry_q   <= carry_d;
      illegal_q <= illegal_d;
      done_q    <= done_d;
    end
  end

  assign Result  = result_q;
  assign Zero    = zero_q;
  assign Carry   = carry_q;
  assign Illegal = illegal_q;
  assign busy    = (state_q == SHIFT);
  assign done    = done_q;

endmodule : alu_iterative_exec

// File: tb/tb_alu_iterative_exec.sv
// Directed bench for alu_iterative_exec with hand-computed expected values.
module tb_alu_iterative_exec;

  localparam logic [5:0] F_ADDU = 6'b001011;
  localparam logic [5:0] F_SUBU = 6'b001101;
  localparam logic [5:0] F_AND  = 6'b010010;
  localparam logic [5:0] F_SLL  = 6'b100110;
  localparam logic [5:0] F_BAD  = 6'b000000;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [5:0]  Funct;
  logic [31:0] Src1;
  logic [31:0] Src2;
  logic [4:0]  Shamt;
  logic [31:0] Result;
  logic        Zero;
  logic        Carry;
  logic        Illegal;
  logic        busy;
  logic        done;

  int n_checks = 0;
  int n_pass   = 0;

  alu_iterative_exec #(
    .WIDTH (32),
    .SHW   (5)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .Funct   (Funct),
    .Src1    (Src1),
    .Src2    (Src2),
    .Shamt   (Shamt),
    .Result  (Result),
    .Zero    (Zero),
    .Carry   (Carry),
    .Illegal (Illegal),
    .busy    (busy),
    .done    (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents one request for a single cycle; returns just after the accept edge.
  task automatic issue(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] sh);
    Funct = f;
    Src1  = a;
    Src2  = b;
    Shamt = sh;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Counts edges until done, bounded by max.
  task automatic wait_done(input int max, output int cyc, output int nb);
    cyc = 0;
    nb  = 0;
    while (!done && cyc < max) begin
      if (busy) nb++;
      tick();
      cyc++;
    end
  endtask

  initial begin
    int cyc;
    int nb;
    int nd;

    rst_n = 1'b0;
    start = 1'b0;
    Funct = '0;
    Src1  = '0;
    Src2  = '0;
    Shamt = '0;
    #12;
    check_eq("rst_result", Result, 32'h0);
    check_eq("rst_zero", 32'(Zero), 32'd0);
    check_eq("rst_carry", 32'(Carry), 32'd0);
    check_eq("rst_illegal", 32'(Illegal), 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_done", 32'(done), 32'd0);
    rst_n = 1'b1;

    // addu 5 + 7
    issue(F_ADDU, 32'd5, 32'd7, 5'd0);
    check_eq("addu_result", Result, 32'd12);
    check_eq("addu_zero", 32'(Zero), 32'd0);
    check_eq("addu_carry", 32'(Carry), 32'd0);
    check_eq("addu_done", 32'(done), 32'd1);
    tick();
    check_eq("addu_done_drop", 32'(done), 32'd0);
    check_eq("addu_hold", Result, 32'd12);

    // addu wrap
    issue(F_ADDU, 32'hFFFF_FFFF, 32'd1, 5'd0);
    check_eq("wrap_result", Result, 32'h0);
    check_eq("wrap_zero", 32'(Zero), 32'd1);
    check_eq("wrap_carry", 32'(Carry), 32'd1);

    // subu then and back-to-back
    issue(F_SUBU, 32'd3, 32'd5, 5'd0);
    check_eq("subu_result", Result, 32'hFFFF_FFFE);
    check_eq("subu_carry", 32'(Carry), 32'd1);
    check_eq("subu_zero", 32'(Zero), 32'd0);
    check_eq("subu_done", 32'(done), 32'd1);
    issue(F_AND, 32'hF0F0_F0F0, 32'hFF00_FF00, 5'd0);
    check_eq("and_result", Result, 32'hF000_F000);
    check_eq("and_carry", 32'(Carry), 32'd0);
    check_eq("and_done", 32'(done), 32'd1);
    tick();

    // sll by 4 with a start pulse (and operand change) during busy
    issue(F_SLL, 32'd1, 32'h0, 5'd4);
    check_eq("sll4_busy", 32'(busy), 32'd1);
    check_eq("sll4_done_early", 32'(done), 32'd0);
    cyc = 0;
    nb  = 0;
    while (!done && cyc < 40) begin
      if (busy) nb++;
      start = (cyc == 1);
      if (cyc == 1) begin
        Funct = F_ADDU;
        Src1  = 32'd99;
        Src2  = 32'd1;
      end
      tick();
      cyc++;
    end
    start = 1'b0;
    check_eq("sll4_edges", 32'(cyc), 32'd4);
    check_eq("sll4_busy_cycles", 32'(nb), 32'd4);
    check_eq("sll4_result", Result, 32'h0000_0010);
    check_eq("sll4_busy_with_done", 32'(busy), 32'd0);
    check_eq("sll4_carry", 32'(Carry), 32'd0);
    nd = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (done) nd++;
    end
    check_eq("sll4_no_extra_done", 32'(nd), 32'd0);
    check_eq("sll4_hold", Result, 32'h0000_0010);

    // sll by 0
    issue(F_SLL, 32'hDEAD_BEEF, 32'h0, 5'd0);
    check_eq("sll0_result", Result, 32'hDEAD_BEEF);
    check_eq("sll0_done", 32'(done), 32'd1);
    check_eq("sll0_busy", 32'(busy), 32'd0);

    // sll by 31
    issue(F_SLL, 32'd3, 32'h0, 5'd31);
    wait_done(40, cyc, nb);
    check_eq("sll31_edges", 32'(cyc), 32'd31);
    check_eq("sll31_busy_cycles", 32'(nb), 32'd31);
    check_eq("sll31_result", Result, 32'h8000_0000);
    check_eq("sll31_zero", 32'(Zero), 32'd0);

    // illegal opcode
    issue(F_BAD, 32'd5, 32'd6, 5'd0);
    check_eq("ill_flag", 32'(Illegal), 32'd1);
    check_eq("ill_result", Result, 32'h0);
    check_eq("ill_zero", 32'(Zero), 32'd1);
    check_eq("ill_carry", 32'(Carry), 32'd0);
    check_eq("ill_done", 32'(done), 32'd1);

    // reset mid-shift
    issue(F_SLL, 32'd1, 32'h0, 5'd10);
    tick();
    tick();
    check_eq("rstmid_busy_before", 32'(busy), 32'd1);
    #3;
    rst_n = 1'b0;
    #1;
    check_eq("rstmid_busy", 32'(busy), 32'd0);
    check_eq("rstmid_illegal", 32'(Illegal), 32'd0);
    check_eq("rstmid_zero", 32'(Zero), 32'd0);
    check_eq("rstmid_done", 32'(done), 32'd0);
    tick();
    rst_n = 1'b1;
    nd = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (done) nd++;
    end
    check_eq("rstmid_no_done", 32'(nd), 32'd0);
    issue(F_ADDU, 32'd5, 32'd7, 5'd0);
    check_eq("post_rst_result", Result, 32'd12);
    check_eq("post_rst_done", 32'(done), 32'd1);
    check_eq("post_rst_illegal", 32'(Illegal), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_alu_iterative_exec
